// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between a core and the data memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] din;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] dout;
  logic        resp_error;

  modport master (
    output req_valid, mem_read, mem_write, addr, din, resp_ready,
    input  req_ready, resp_valid, dout, resp_error
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, din, resp_ready,
    output req_ready, resp_valid, dout, resp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory responder with valid/ready request and response
module dmem_responder #(
  parameter int DEPTH   = 16384,
  parameter int LATENCY = 3
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [31:0]   addr_q;
  logic [31:0]   din_q;
  logic          rd_q;
  logic          wr_q;
  logic [31:0]   dout_q;
  logic          error_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          commit;
  logic [31:0]   c_addr;
  logic [31:0]   c_din;
  logic          c_rd;
  logic          c_wr;
  logic          c_err;
  logic [AW-1:0] c_idx;

  assign accept = (state == IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);

  // The accepting edge is the first of the LATENCY edges, so LATENCY=1 commits on that edge.
  assign commit = !reset &&
                  (((state == WAIT) && (count == CW'(1))) || (accept && (LATENCY == 1)));

  // On a same-edge commit the request is still on the inputs; otherwise use the latched copy.
  assign c_addr = (state == IDLE) ? bus.addr      : addr_q;
  assign c_din  = (state == IDLE) ? bus.din       : din_q;
  assign c_rd   = (state == IDLE) ? bus.mem_read  : rd_q;
  assign c_wr   = (state == IDLE) ? bus.mem_write : wr_q;

  // Word index is compared unsigned over the full 30 bits so high addresses never alias.
  assign c_err = (c_rd && c_wr) || (c_addr[1:0] != 2'b00) ||
                 ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
  assign c_idx = c_addr[AW+1:2];

  // State register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? DONE : WAIT;
      WAIT:    if (count == CW'(1)) state_next = DONE;
      DONE:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE:    bus.req_ready  = 1'b1;
      DONE:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture, latency counter and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        count  <= CNT_LOAD;
        addr_q <= bus.addr;
        din_q  <= bus.din;
        rd_q   <= bus.mem_read;
        wr_q   <= bus.mem_write;
      end else if (state == WAIT) begin
        count <= count - CW'(1);
      end
      if (commit) begin
        error_q <= c_err;
        dout_q  <= (c_rd && !c_err) ? mem[c_idx] : 32'h0;
      end
    end
  end

  // Array write port: only error-free stores touch the array, and only on the commit edge.
  always_ff @(posedge clk) begin
    if (commit && c_wr && !c_err) mem[c_idx] <= c_din;
  end

  assign bus.dout       = dout_q;
  assign bus.resp_error = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int DEPTH_A = 16384;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH(DEPTH_A), .LATENCY(3)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  dmem_responder #(.DEPTH(DEPTH_B), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_bus(virtual dmem_responder_if v);
    v.req_valid  = 1'b0;
    v.mem_read   = 1'b0;
    v.mem_write  = 1'b0;
    v.addr       = 32'h0;
    v.din        = 32'h0;
    v.resp_ready = 1'b0;
  endtask

  // Present a request, then scramble the inputs and wait (bounded) for resp_valid.
  task automatic issue(virtual dmem_responder_if v, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    v.req_valid = 1'b1;
    v.mem_read  = rd;
    v.mem_write = wr;
    v.addr      = a;
    v.din       = d;
    @(posedge clk);
    @(negedge clk);
    v.req_valid = 1'b0;
    v.mem_read  = ~rd;
    v.mem_write = ~wr;
    v.addr      = ~a;
    v.din       = ~d;
    lat = 1;
    while (!v.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    v.mem_read  = 1'b0;
    v.mem_write = 1'b0;
  endtask

  task automatic consume(virtual dmem_responder_if v, input string tag);
    v.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v.resp_ready = 1'b0;
    check_eq({tag, "_rv_drop"}, 32'(v.resp_valid), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(v.req_ready), 32'd1);
  endtask

  task automatic txn(virtual dmem_responder_if v, input string tag, input logic rd,
                     input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input logic [31:0] exp_dout, input logic exp_err);
    int lat;
    issue(v, rd, wr, a, d, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_dout"}, v.dout, exp_dout);
    check_eq({tag, "_err"}, 32'(v.resp_error), 32'(exp_err));
    consume(v, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    idle_bus(bus_a);
    idle_bus(bus_b);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check_eq("rst_dout", bus_a.dout, 32'h0);
    check_eq("rst_err", 32'(bus_a.resp_error), 32'd0);
    check_eq("rst_b_req_ready", 32'(bus_b.req_ready), 32'd1);
    reset = 1'b0;

    txn(bus_a, "st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0);

    // Load with a long stall; a new request during DONE must be ignored.
    issue(bus_a, 1'b1, 1'b0, 32'h10, 32'h0, lat);
    check_eq("ld10_lat", 32'(lat), 32'd3);
    check_eq("ld10_dout", bus_a.dout, 32'hDEADBEEF);
    check_eq("ld10_err", 32'(bus_a.resp_error), 32'd0);
    bus_a.req_valid = 1'b1;
    bus_a.mem_write = 1'b1;
    bus_a.addr      = 32'h10;
    bus_a.din       = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_rv", 32'(bus_a.resp_valid), 32'd1);
      check_eq("hold_dout", bus_a.dout, 32'hDEADBEEF);
      check_eq("hold_rdy", 32'(bus_a.req_ready), 32'd0);
    end
    idle_bus(bus_a);
    consume(bus_a, "hold");
    txn(bus_a, "ld10_after_hold", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    txn(bus_a, "st13_mis", 1'b0, 1'b1, 32'h13, 32'h11111111, 3, 32'h0, 1'b1);
    txn(bus_a, "ld10_keep", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    txn(bus_a, "both_ops", 1'b1, 1'b1, 32'h10, 32'h22222222, 3, 32'h0, 1'b1);
    txn(bus_a, "ld10_both", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    txn(bus_a, "ld_oor", 1'b1, 1'b0, 32'(DEPTH_A * 4), 32'h0, 3, 32'h0, 1'b1);
    txn(bus_a, "ld_hi", 1'b1, 1'b0, 32'h80000010, 32'h0, 3, 32'h0, 1'b1);
    txn(bus_a, "st_last", 1'b0, 1'b1, 32'(DEPTH_A * 4 - 4), 32'h12345678, 3, 32'h0, 1'b0);
    txn(bus_a, "ld_last", 1'b1, 1'b0, 32'(DEPTH_A * 4 - 4), 32'h0, 3, 32'h12345678, 1'b0);

    // Reset in WAIT discards a pending store.
    txn(bus_a, "st20_zero", 1'b0, 1'b1, 32'h20, 32'h0, 3, 32'h0, 1'b0);
    txn(bus_a, "ld10_pre", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.mem_write = 1'b1;
    bus_a.addr      = 32'h20;
    bus_a.din       = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    idle_bus(bus_a);
    reset = 1'b1;
    #1;
    check_eq("rstw_req_ready", 32'(bus_a.req_ready), 32'd1);
    check_eq("rstw_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check_eq("rstw_dout", bus_a.dout, 32'h0);
    check_eq("rstw_err", 32'(bus_a.resp_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txn(bus_a, "ld20_abort", 1'b1, 1'b0, 32'h20, 32'h0, 3, 32'h0, 1'b0);

    // Reset in DONE keeps the already-committed store.
    issue(bus_a, 1'b0, 1'b1, 32'h24, 32'hA5A5A5A5, lat);
    check_eq("st24_lat", 32'(lat), 32'd3);
    reset = 1'b1;
    #1;
    check_eq("rstd_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check_eq("rstd_req_ready", 32'(bus_a.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    txn(bus_a, "ld24_kept", 1'b1, 1'b0, 32'h24, 32'h0, 3, 32'hA5A5A5A5, 1'b0);

    // LATENCY=1 instance: no-op request is ignored, then single-edge transactions.
    @(negedge clk);
    bus_b.req_valid = 1'b1;
    bus_b.addr      = 32'h8;
    @(posedge clk);
    @(negedge clk);
    check_eq("b_noop_rdy", 32'(bus_b.req_ready), 32'd1);
    check_eq("b_noop_rv", 32'(bus_b.resp_valid), 32'd0);
    idle_bus(bus_b);
    txn(bus_b, "b_st8", 1'b0, 1'b1, 32'h8, 32'h00000077, 1, 32'h0, 1'b0);
    txn(bus_b, "b_ld8", 1'b1, 1'b0, 32'h8, 32'h0, 1, 32'h00000077, 1'b0);
    txn(bus_b, "b_oor", 1'b1, 1'b0, 32'(DEPTH_B * 4), 32'h0, 1, 32'h0, 1'b1);
    txn(bus_b, "b_ld_last", 1'b1, 1'b0, 32'(DEPTH_B * 4 - 4), 32'h0, 1, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
